// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART command deframer: parser state encoding,
// default frame-start marker, frame length and the frame checksum rule.
package uart_frame_parser_pkg;

  typedef enum logic [2:0] {
    SYNC = 3'd0,
    ADDR = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CSUM = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN         = 5;

  // A frame is good when the XOR of address, both data bytes and the
  // checksum byte is zero.
  function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                            input logic [7:0] dhi,
                                            input logic [7:0] dlo,
                                            input logic [7:0] csum);
    return addr ^ dhi ^ dlo ^ csum;
  endfunction

endpackage

// File: rtl/uart_frame_parser.sv
// Byte-level command deframer. Assembles sync/addr/data_hi/data_lo/checksum
// frames from a UART receiver byte stream into 16-bit register-write
// commands, flagging checksum failures and inter-byte timeouts.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        cmd_valid,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        csum_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYCLES);

  state_e          state_q;
  logic [7:0]      addr_q;
  logic [7:0]      dhi_q;
  logic [7:0]      dlo_q;
  logic [7:0]      cmd_addr_q;
  logic [15:0]     cmd_data_q;
  logic            cmd_valid_q;
  logic            csum_err_q;
  logic            timeout_err_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            expire;

  // Inter-byte gap counter: idle in SYNC, restarts on every byte, saturates.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (rx_valid || (state_q == SYNC)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_SAT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign expire = (state_q != SYNC) && !rx_valid && (to_cnt_q == TO_LAST);

  // Gap counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // Frame FSM with registered command and error strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SYNC;
      addr_q        <= 8'h00;
      dhi_q         <= 8'h00;
      dlo_q         <= 8'h00;
      cmd_addr_q    <= 8'h00;
      cmd_data_q    <= 16'h0000;
      cmd_valid_q   <= 1'b0;
      csum_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      cmd_valid_q   <= 1'b0;
      csum_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      if (rx_valid) begin
        case (state_q)
          SYNC: begin
            if (rx_byte == SYNC_BYTE) begin
              state_q <= ADDR;
            end
          end
          ADDR: begin
            addr_q  <= rx_byte;
            state_q <= DHI;
          end
          DHI: begin
            dhi_q   <= rx_byte;
            state_q <= DLO;
          end
          DLO: begin
            dlo_q   <= rx_byte;
            state_q <= CSUM;
          end
          CSUM: begin
            if (frame_csum(addr_q, dhi_q, dlo_q, rx_byte) == 8'h00) begin
              cmd_addr_q  <= addr_q;
              cmd_data_q  <= {dhi_q, dlo_q};
              cmd_valid_q <= 1'b1;
            end else begin
              csum_err_q  <= 1'b1;
            end
            state_q <= SYNC;
          end
          default: begin
            state_q <= SYNC;
          end
        endcase
      end else if (expire) begin
        state_q       <= SYNC;
        addr_q        <= 8'h00;
        dhi_q         <= 8'h00;
        dlo_q         <= 8'h00;
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_data    = cmd_data_q;
  assign csum_err    = csum_err_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != SYNC);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Testbench for uart_frame_parser: table-driven frames, hand-written timeout
// and reset sequences, and randomized frame traffic against a queue-based
// reference model of the frame rules.
module tb_uart_frame_parser;
  import uart_frame_parser_pkg::*;

  localparam int         TO  = 16;
  localparam logic [7:0] SB  = 8'hA5;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        cmd_valid;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        csum_err;
  logic        timeout_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_frame_parser #(
    .SYNC_BYTE     (SB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .cmd_valid  (cmd_valid),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .csum_err   (csum_err),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bytes of the frame in progress, gap since last byte.
  logic [7:0]  mq[$];
  int          gap;
  logic        e_cmd, e_csum, e_to, e_busy;
  logic [7:0]  e_addr;
  logic [15:0] e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    gap    = 0;
    e_cmd  = 1'b0;
    e_csum = 1'b0;
    e_to   = 1'b0;
    e_busy = 1'b0;
    e_addr = 8'h00;
    e_data = 16'h0000;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    logic [7:0] x;
    e_cmd  = 1'b0;
    e_csum = 1'b0;
    e_to   = 1'b0;
    if (v) begin
      gap = 0;
      if (mq.size() == 0) begin
        if (b == SB) mq.push_back(b);
      end else begin
        mq.push_back(b);
        if (mq.size() == FRAME_LEN) begin
          x = mq[1] ^ mq[2] ^ mq[3] ^ mq[4];
          if (x == 8'h00) begin
            e_cmd  = 1'b1;
            e_addr = mq[1];
            e_data = {mq[2], mq[3]};
          end else begin
            e_csum = 1'b1;
          end
          mq.delete();
        end
      end
    end else if (mq.size() != 0) begin
      gap++;
      if (gap == TO) begin
        e_to = 1'b1;
        mq.delete();
      end
    end
    e_busy = (mq.size() != 0);
  endtask

  task automatic model_cmp();
    chk("m_cmd_valid",   32'(cmd_valid),   32'(e_cmd));
    chk("m_csum_err",    32'(csum_err),    32'(e_csum));
    chk("m_timeout_err", 32'(timeout_err), 32'(e_to));
    chk("m_busy",        32'(busy),        32'(e_busy));
    chk("m_cmd_addr",    32'(cmd_addr),    32'(e_addr));
    chk("m_cmd_data",    32'(cmd_data),    32'(e_data));
  endtask

  // One clock cycle; rx_byte gets junk when rx_valid is low.
  task automatic cyc(input logic v, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_byte  = v ? b : 8'($urandom);
    @(posedge clk);
    model_step(v, b);
    #1;
    model_cmp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_valid"},   32'(cmd_valid),   32'd0);
    chk({tag, "_csum_err"},    32'(csum_err),    32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_busy"},        32'(busy),        32'd0);
    chk({tag, "_cmd_addr"},    32'(cmd_addr),    32'h00);
    chk({tag, "_cmd_data"},    32'(cmd_data),    32'h0000);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        cmd;
    logic        cerr;
    logic        terr;
    logic        bsy;
    logic [7:0]  addr;
    logic [15:0] data;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // Back-to-back: good frame, bad checksum, garbage then good frame.
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000};
    tbl[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000};
    tbl[2]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000};
    tbl[3]  = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000};
    tbl[4]  = '{1'b1, 8'h70, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 16'h3456};
    tbl[5]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h3456};
    tbl[6]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h3456};
    tbl[7]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h3456};
    tbl[8]  = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h3456};
    tbl[9]  = '{1'b1, 8'h71, 1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 16'h3456};
    tbl[10] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 16'h3456};
    tbl[11] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 16'h3456};
    tbl[12] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h3456};
    tbl[13] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h3456};
    tbl[14] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h3456};
    tbl[15] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 16'h3456};
    tbl[16] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 16'h0002};
    tbl[17] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'h0002};

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors.
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].v, tbl[i].b);
      chk($sformatf("tbl%0d_cmd_valid", i),   32'(cmd_valid),   32'(tbl[i].cmd));
      chk($sformatf("tbl%0d_csum_err", i),    32'(csum_err),    32'(tbl[i].cerr));
      chk($sformatf("tbl%0d_timeout_err", i), 32'(timeout_err), 32'(tbl[i].terr));
      chk($sformatf("tbl%0d_busy", i),        32'(busy),        32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_cmd_addr", i),    32'(cmd_addr),    32'(tbl[i].addr));
      chk($sformatf("tbl%0d_cmd_data", i),    32'(cmd_data),    32'(tbl[i].data));
    end

    // Good frame with spaced bytes (gap below the timeout).
    begin
      logic [7:0] fr [5];
      fr = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h70};
      for (int i = 0; i < 5; i++) begin
        cyc(1'b1, fr[i]);
        if (i < 4) begin
          chk("spaced_no_cmd", 32'(cmd_valid), 32'd0);
          idle(TO - 4);
        end
      end
      chk("spaced_cmd_valid", 32'(cmd_valid), 32'd1);
      chk("spaced_cmd_addr",  32'(cmd_addr),  32'h12);
      chk("spaced_cmd_data",  32'(cmd_data),  32'h3456);
      cyc(1'b0, 8'h00);
      chk("spaced_cmd_once",  32'(cmd_valid), 32'd0);
    end

    // Timeout: A5 01 then silence.
    cyc(1'b1, 8'hA5);
    cyc(1'b1, 8'h01);
    for (int i = 1; i < TO; i++) begin
      cyc(1'b0, 8'h00);
      chk("to_early", 32'(timeout_err), 32'd0);
      chk("to_busy_hold", 32'(busy), 32'd1);
    end
    cyc(1'b0, 8'h00);
    chk("to_err_at_limit", 32'(timeout_err), 32'd1);
    chk("to_busy_low",     32'(busy),        32'd0);
    chk("to_no_cmd",       32'(cmd_valid),   32'd0);
    cyc(1'b0, 8'h00);
    chk("to_err_once", 32'(timeout_err), 32'd0);
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h10); cyc(1'b1, 8'h20); cyc(1'b1, 8'h30); cyc(1'b1, 8'h00);
    chk("to_after_cmd",  32'(cmd_valid), 32'd1);
    chk("to_after_addr", 32'(cmd_addr),  32'h10);
    chk("to_after_data", 32'(cmd_data),  32'h2030);

    // Bytes landing exactly in the expiry cycle are accepted.
    cyc(1'b1, 8'hA5);
    cyc(1'b1, 8'h01);
    idle(TO - 1);
    cyc(1'b1, 8'h02);
    chk("exp_byte_no_to", 32'(timeout_err), 32'd0);
    chk("exp_byte_busy",  32'(busy),        32'd1);
    idle(TO - 1);
    cyc(1'b1, 8'h03);
    chk("exp_byte2_no_to", 32'(timeout_err), 32'd0);
    idle(TO - 1);
    cyc(1'b1, 8'h00);
    chk("exp_cmd",      32'(cmd_valid),   32'd1);
    chk("exp_cmd_addr", 32'(cmd_addr),    32'h01);
    chk("exp_cmd_data", 32'(cmd_data),    32'h0203);
    chk("exp_no_to",    32'(timeout_err), 32'd0);

    // Reset mid-frame.
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h10); cyc(1'b1, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_vals("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h30); cyc(1'b1, 8'h40); cyc(1'b1, 8'h05);
    chk("post_rst_idle_busy", 32'(busy),      32'd0);
    chk("post_rst_no_cmd",    32'(cmd_valid), 32'd0);
    chk("post_rst_no_csum",   32'(csum_err),  32'd0);
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h11); cyc(1'b1, 8'h22); cyc(1'b1, 8'h33); cyc(1'b1, 8'h00);
    chk("post_rst_cmd",  32'(cmd_valid), 32'd1);
    chk("post_rst_addr", 32'(cmd_addr),  32'h11);
    chk("post_rst_data", 32'(cmd_data),  32'h2233);

    // Randomized frame traffic against the model.
    for (int f = 0; f < 150; f++) begin
      logic [7:0] a, h, l, c;
      int nb;
      a  = 8'($urandom);
      h  = 8'($urandom);
      l  = 8'($urandom);
      c  = ($urandom_range(0, 3) != 0) ? (a ^ h ^ l) : 8'($urandom);
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 5;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        cyc(1'b1, 8'($urandom));
        idle($urandom_range(0, 2));
      end
      for (int k = 0; k < nb; k++) begin
        case (k)
          0: cyc(1'b1, SB);
          1: cyc(1'b1, a);
          2: cyc(1'b1, h);
          3: cyc(1'b1, l);
          default: cyc(1'b1, c);
        endcase
        if ($urandom_range(0, 9) == 0) idle($urandom_range(TO - 2, TO + 2));
        else idle($urandom_range(0, 3));
      end
    end
    idle(TO + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
